// File: rtl/input_conditioner_if.sv
// Raw button/switch levels in, debounced levels and edge pulses out.
interface input_conditioner_if #(
  parameter int NCH = 3
);
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] clean;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;

  modport master (
    output raw_in,
    input  clean,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  raw_in,
    output clean,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel polarity fix, 2-flop synchronizer and counter debouncer that
// produces a clean level plus one-cycle rise/fall pulses for each input.
module input_conditioner #(
  parameter int             NCH             = 3,
  parameter int             DEBOUNCE_CYCLES = 16,
  parameter logic [NCH-1:0] ACTIVE_LOW_MASK = '0
) (
  input logic               clk,
  input logic               g_reset,
  input_conditioner_if.slave bus
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] pol;
  logic [NCH-1:0] s1_reg;
  logic [NCH-1:0] s2_reg;
  logic [NCH-1:0] clean_vec;
  logic [NCH-1:0] rise_vec;
  logic [NCH-1:0] fall_vec;

  // Inversion happens before the first flop so s1->s2 is a pure flop pair.
  assign pol = bus.raw_in ^ ACTIVE_LOW_MASK;

  always_ff @(posedge clk or negedge g_reset) begin
    if (!g_reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= pol;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          clean_reg;
      logic          clean_next;
      logic          rise_reg;
      logic          rise_next;
      logic          fall_reg;
      logic          fall_next;

      // Counter tracks consecutive cycles where s2 disagrees with clean;
      // any agreement discards progress, so short glitches never land.
      always_comb begin
        cnt_next   = cnt_reg + CW'(1);
        clean_next = clean_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (s2_reg[gi] == clean_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          clean_next = s2_reg[gi];
          rise_next  = s2_reg[gi];
          fall_next  = ~s2_reg[gi];
        end
      end

      always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          clean_reg <= clean_next;
          rise_reg  <= rise_next;
          fall_reg  <= fall_next;
        end
      end

      assign clean_vec[gi] = clean_reg;
      assign rise_vec[gi]  = rise_reg;
      assign fall_vec[gi]  = fall_reg;
    end
  endgenerate

  assign bus.clean      = clean_vec;
  assign bus.rise_pulse = rise_vec;
  assign bus.fall_pulse = fall_vec;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: two instances (plain and channel-2 active-low)
// share one raw input and are compared every cycle to a window-based model.
module tb_input_conditioner;

  localparam int NCH = 3;
  localparam int D   = 4;

  logic           clk = 1'b0;
  logic           g_reset;
  logic [NCH-1:0] raw;

  int n_checks = 0;
  int n_fail   = 0;

  input_conditioner_if #(.NCH(NCH)) if_a ();
  input_conditioner_if #(.NCH(NCH)) if_b ();

  assign if_a.raw_in = raw;
  assign if_b.raw_in = raw;

  input_conditioner #(
    .NCH(NCH), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_MASK(3'b000)
  ) dut_a (
    .clk(clk), .g_reset(g_reset), .bus(if_a.slave)
  );

  input_conditioner #(
    .NCH(NCH), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_MASK(3'b100)
  ) dut_b (
    .clk(clk), .g_reset(g_reset), .bus(if_b.slave)
  );

  always #5 clk = ~clk;

  // Model: a value reaches clean once the last D post-sync samples all
  // disagree with the current clean level.
  logic [NCH-1:0] mask_m  [2];
  logic [NCH-1:0] dly1_m  [2];
  logic [NCH-1:0] dly2_m  [2];
  logic [NCH-1:0] clean_m [2];
  logic [NCH-1:0] rise_m  [2];
  logic [NCH-1:0] fall_m  [2];
  logic [D-1:0]   win_m   [2][NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] get_clean(input int d);
    return (d == 0) ? if_a.clean : if_b.clean;
  endfunction

  function automatic logic [NCH-1:0] get_rise(input int d);
    return (d == 0) ? if_a.rise_pulse : if_b.rise_pulse;
  endfunction

  function automatic logic [NCH-1:0] get_fall(input int d);
    return (d == 0) ? if_a.fall_pulse : if_b.fall_pulse;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      dly1_m[d]  = '0;
      dly2_m[d]  = '0;
      clean_m[d] = '0;
      rise_m[d]  = '0;
      fall_m[d]  = '0;
      for (int c = 0; c < NCH; c++) win_m[d][c] = '0;
    end
  endtask

  task automatic model_edge();
    logic [NCH-1:0] s2;
    for (int d = 0; d < 2; d++) begin
      s2        = dly2_m[d];
      dly2_m[d] = dly1_m[d];
      dly1_m[d] = raw ^ mask_m[d];
      rise_m[d] = '0;
      fall_m[d] = '0;
      for (int c = 0; c < NCH; c++) begin
        win_m[d][c] = {win_m[d][c][D-2:0], s2[c]};
        if (win_m[d][c] == (clean_m[d][c] ? {D{1'b0}} : {D{1'b1}})) begin
          clean_m[d][c] = ~clean_m[d][c];
          rise_m[d][c]  = clean_m[d][c];
          fall_m[d][c]  = ~clean_m[d][c];
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_clean%0d", where, d), 32'(get_clean(d)), 32'(clean_m[d]));
      check($sformatf("%s_rise%0d", where, d),  32'(get_rise(d)),  32'(rise_m[d]));
      check($sformatf("%s_fall%0d", where, d),  32'(get_fall(d)),  32'(fall_m[d]));
    end
  endtask

  task automatic tick(input string where);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(where);
  endtask

  task automatic check_all_zero(input string where);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_clean%0d", where, d), 32'(get_clean(d)), 32'(0));
      check($sformatf("%s_rise%0d", where, d),  32'(get_rise(d)),  32'(0));
      check($sformatf("%s_fall%0d", where, d),  32'(get_fall(d)),  32'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int seen;
    logic [NCH-1:0] rp;

    mask_m[0] = 3'b000;
    mask_m[1] = 3'b100;
    model_reset();

    // Asynchronous reset visible before any clock edge.
    g_reset = 1'b0;
    raw     = 3'b111;
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset_held");
    raw     = 3'b000;
    g_reset = 1'b1;

    // Clean press on channel 1.
    raw[1] = 1'b1;
    n = 0;
    while (!if_a.rise_pulse[1] && n < 20) begin
      tick("press");
      n++;
    end
    check("press_latency", 32'(n), 32'(D + 2));
    check("press_clean", 32'(if_a.clean[1]), 32'(1));
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick("press_hold");
      pulses += int'(if_a.rise_pulse[1]) + int'(if_a.fall_pulse[1]);
    end
    check("press_norefire", 32'(pulses), 32'(0));

    // Bounce on channel 0, 2-cycle dwell, then settle high.
    seen = 0;
    for (int b = 0; b < 4; b++) begin
      raw[0] = (b % 2 == 0);
      repeat (2) begin
        tick("bounce");
        seen += int'(if_a.clean[0]);
      end
    end
    check("bounce_reject", 32'(seen), 32'(0));
    raw[0] = 1'b1;
    n = 0; pulses = 0;
    while (!if_a.clean[0] && n < 20) begin
      tick("settle");
      n++;
      pulses += int'(if_a.rise_pulse[0]);
    end
    check("settle_latency", 32'(n), 32'(D + 2));
    check("settle_pulses", 32'(pulses), 32'(1));

    // Press then release channel 2.
    raw[2] = 1'b1;
    n = 0;
    while (!if_a.clean[2] && n < 20) begin
      tick("ch2_press");
      n++;
    end
    check("ch2_press_latency", 32'(n), 32'(D + 2));
    tick("ch2_hold");
    raw[2] = 1'b0;
    n = 0; pulses = 0;
    while (!if_a.fall_pulse[2] && n < 20) begin
      tick("release");
      n++;
      pulses += int'(if_a.rise_pulse[2]);
    end
    check("release_latency", 32'(n), 32'(D + 2));
    check("release_clean", 32'(if_a.clean[2]), 32'(0));
    check("release_norise", 32'(pulses), 32'(0));

    // Simultaneous rise on all channels of the mixed-polarity instance.
    raw = 3'b100;
    repeat (12) tick("simul_settle");
    check("simul_pre", 32'(if_b.clean), 32'(0));
    raw = 3'b011;
    n = 0; rp = '0;
    while (if_b.clean != 3'b111 && n < 20) begin
      tick("simul");
      n++;
      rp = if_b.rise_pulse;
    end
    check("simul_latency", 32'(n), 32'(D + 2));
    check("simul_rise", 32'(rp), 32'(3'b111));
    tick("simul_after");
    check("simul_single", 32'(if_b.rise_pulse), 32'(0));

    // Reset in the middle of a count, raw held through release.
    raw = 3'b000;
    repeat (12) tick("mid_settle");
    raw[0] = 1'b1;
    repeat (3) tick("mid_count");
    #2;
    g_reset = 1'b0;
    #1;
    check_all_zero("mid_reset_async");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("mid_reset_held");
    g_reset = 1'b1;
    n = 0;
    while (!if_a.clean[0] && n < 20) begin
      tick("mid_release");
      n++;
    end
    check("mid_latency", 32'(n), 32'(D + 2));
    check("mid_rise", 32'(if_a.rise_pulse[0]), 32'(1));

    // Randomized bouncing on all channels against the model.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
      end
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that cleans the raw push-button/switch inputs (sensor, walk_request, reprogram) before they enter the traffic-light labkit.
- Each channel goes through polarity correction, a 2-flop synchronizer and a counter-based debouncer.
- Outputs per channel: a clean level, a one-cycle rise pulse and a one-cycle fall pulse.
- labkit consumes the clean levels for sensor and the rise pulses for walk_request and reprogram.

Parameters:
- NCH, 3, number of independent input channels (bit 0 sensor, bit 1 walk_request, bit 2 reprogram).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before clean output changes; legal range 1..65535.
- ACTIVE_LOW_MASK, 3'b000, per-bit: 1 = raw input is active-low and is inverted before synchronization.

Ports:
- clk  input  1  system clock; all state on rising edge.
- g_reset  input  1  asynchronous active-low reset.
- raw_in  input  NCH  asynchronous raw button/switch levels.
- clean  output  NCH  debounced, synchronized, active-high level.
- rise_pulse  output  NCH  one-cycle high when clean goes 0->1.
- fall_pulse  output  NCH  one-cycle high when clean goes 1->0.

Behaviour:
- Reset (g_reset=0, asynchronous) clears:
  - sync stages, counters, clean, rise_pulse and fall_pulse to 0;
  - the internal clean-delay register to 0.
- Release is synchronous to the next clk edge.
- Polarity: pol[i] = raw_in[i] XOR ACTIVE_LOW_MASK[i], applied before the first flop.
- Synchronizer: s1 <= pol, s2 <= s1. No logic between s1 and s2.
- Debouncer per channel:
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
  - If s2 == clean: counter <= 0.
  - If s2 != clean and counter == DEBOUNCE_CYCLES-1: clean <= s2 and counter <= 0.
  - Else: counter <= counter+1.
- Latency:
  - Edge 0 is the first rising edge that samples a new stable raw value.
  - clean changes on edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges inclusive.
- Glitch rejection: any return of s2 to the current clean value before the count completes clears the counter. Pulses shorter than DEBOUNCE_CYCLES cycles (after sync) never reach clean.
- Pulses:
  - rise_pulse[i] and fall_pulse[i] are registered and assert on the same edge that clean[i] changes.
  - Each lasts exactly one cycle.
  - They are never both high.
  - They do not re-fire while the level is held.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- DEBOUNCE_CYCLES=1: clean follows s2 one cycle later (edge 2 after the change).
- Counter never wraps: the max count is DEBOUNCE_CYCLES-1.
- Reset mid-count: all progress is discarded. If raw stays asserted through release, clean rises (with rise_pulse) DEBOUNCE_CYCLES+2 edges after the first post-release edge.
- No X propagation: outputs are defined from reset onward regardless of raw_in.

Test Plan (DEBOUNCE_CYCLES=4, NCH=3, ACTIVE_LOW_MASK=3'b000 unless stated):
- Reset: hold g_reset=0 with raw_in=3'b111 -> clean=0, rise/fall=0 immediately (asynchronous), before any clk edge.
- Clean press: raw_in[1] 0->1 held -> clean[1]=1 on edge 5 after the first sampling edge; rise_pulse[1] high exactly that one cycle; no further pulses while held.
- Bounce: raw_in[0] toggles 1,0,1,0 with 2-cycle dwell, then settles at 1 -> clean[0] stays 0 through the bounce. It rises 6 edges after the settle, with a single rise_pulse.
- Release: after clean[2]=1, drop raw_in[2] to 0 -> clean[2]=0 and fall_pulse[2] one cycle, 6 edges later; rise_pulse[2] stays 0.
- Simultaneous plus polarity: ACTIVE_LOW_MASK=3'b100; raw_in goes 3'b100->3'b011 on one edge:
  - clean goes 3'b000->3'b111 on a single edge;
  - rise_pulse=3'b111 for one cycle.
- Reset mid-count: raw_in[0]=1 for 3 cycles, pulse g_reset low asynchronously, release with raw held:
  - clean[0] rises 6 edges after release, not earlier;
  - no pulse is emitted during reset.
